// File: rtl/fc_result_fifo_pkg.sv
// Shared definitions for the frequency-counter result FIFO.
// Holds the iomem register offsets, STATUS bit positions, the drop counter
// width and the helper that sizes one stored entry.
package fc_result_fifo_pkg;

    // Address page that selects this block (iomem_addr[31:24])
    localparam logic [7:0] DEC_PAGE        = 8'h03;

    // Register offsets (iomem_addr[7:0])
    localparam logic [7:0] OFF_STATUS      = 8'h20;
    localparam logic [7:0] OFF_HEAD_REF    = 8'h24;
    localparam logic [7:0] OFF_HEAD_SIG    = 8'h28;
    localparam logic [7:0] OFF_HEAD_SIGSYS = 8'h2C;
    localparam logic [7:0] OFF_POP         = 8'h30;
    localparam logic [7:0] OFF_DROPS       = 8'h34;
    localparam logic [7:0] OFF_HEAD_TS     = 8'h38;

    // STATUS layout
    localparam int unsigned ST_LEVEL_LSB = 0;
    localparam int unsigned ST_LEVEL_W   = 7;
    localparam int unsigned ST_EMPTY     = 8;
    localparam int unsigned ST_FULL      = 9;
    localparam int unsigned ST_OVF       = 10;
    localparam int unsigned ST_SEQ_LSB   = 16;
    localparam int unsigned ST_SEQ_W     = 16;

    // POP write: this wdata bit also clears ovf and drop_cnt
    localparam int unsigned POP_CLR_BIT  = 1;

    localparam int unsigned DROP_BITS    = 8;
    localparam int unsigned TS_BITS      = 32;

    // Width of one stored entry: {ts?, ref, sig, sig_sys, seq}
    function automatic int unsigned entry_bits(input int unsigned sig_bits,
                                               input int unsigned sys_bits,
                                               input int unsigned seq_bits,
                                               input bit          with_ts);
        return 2 * sys_bits + sig_bits + seq_bits + (with_ts ? TS_BITS : 0);
    endfunction

endpackage

// File: rtl/fc_result_fifo_mem.sv
// DEPTH-entry FIFO storage with extended read/write pointers.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   push, pop         qualified by the parent (no push when full without pop,
//                     no pop when empty)
//   wr_data           entry written at the tail on push
//   rd_data           head entry, combinational
//   empty, full       pointer-compare flags
//   level             number of stored entries
module fc_result_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned AW = IW + 1;

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] store [DEPTH];

    // Pointer MSBs differ only after the writer has lapped the reader
    assign empty   = (wptr == rptr);
    assign full    = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
    assign level   = wptr - rptr;
    assign rd_data = store[rptr[IW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) store[wptr[IW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fc_result_fifo.sv
// Result FIFO between the frequency counter and the PicoSoC iomem bus.
// Each rising edge of fc_ready queues {ref, sig, sig_sys, seq}; firmware reads
// the head and pops it through memory-mapped registers.
// Optional feature: define FC_RESULT_FIFO_TIMESTAMP_EN to capture a free-running
// 32-bit cycle counter with every entry (readable at HEAD_TS).
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   fc_ref_sys_cnt, fc_sig_cnt,
//   fc_sig_sys_cnt, fc_ready         counter result and its valid strobe
//   iomem_valid/wstrb/addr/wdata     bus request
//   iomem_ready, iomem_rdata         registered one-cycle ack and read data
//   irq                              high while the FIFO holds entries
module fc_result_fifo
    import fc_result_fifo_pkg::*;
#(
    parameter int unsigned SIG_BITS = 32,
    parameter int unsigned SYS_BITS = 32,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SEQ_BITS = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [SYS_BITS-1:0] fc_ref_sys_cnt,
    input  logic [SIG_BITS-1:0] fc_sig_cnt,
    input  logic [SYS_BITS-1:0] fc_sig_sys_cnt,
    input  logic                fc_ready,
    input  logic                iomem_valid,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic                iomem_ready,
    output logic [31:0]         iomem_rdata,
    output logic                irq
);

`ifdef FC_RESULT_FIFO_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    localparam int unsigned AW      = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = entry_bits(SIG_BITS, SYS_BITS, SEQ_BITS, TS_ON);
    localparam int unsigned SSYS_LSB = SEQ_BITS;
    localparam int unsigned SIG_LSB  = SSYS_LSB + SYS_BITS;
    localparam int unsigned REF_LSB  = SIG_LSB + SIG_BITS;

    logic [SEQ_BITS-1:0]  seq;
    logic                 ovf;
    logic [DROP_BITS-1:0] drop_cnt;
    logic                 ready_q;
    logic                 armed;

    logic [ENTRY_W-1:0]   wr_data;
    logic [ENTRY_W-1:0]   head;
    logic                 empty;
    logic                 full;
    logic [AW-1:0]        level;
    logic [AW-1:0]        level_nxt;

    logic [SYS_BITS-1:0]  head_ref;
    logic [SIG_BITS-1:0]  head_sig;
    logic [SYS_BITS-1:0]  head_sigsys;
    logic [SEQ_BITS-1:0]  head_seq;

    logic [7:0]           off;
    logic                 hit;
    logic                 sel;
    logic                 pop_req;
    logic                 clr_req;
    logic                 pop_ok;
    logic                 push_evt;
    logic                 push_ok;
    logic                 drop;
    logic [31:0]          rd_val;
    logic                 bus_unused;

    // Rising-edge detect; armed stays low after reset until fc_ready is seen
    // low, so a strobe held across reset release never pushes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            ready_q <= fc_ready;
            if (!fc_ready) armed <= 1'b1;
        end
    end

    assign push_evt = fc_ready && !ready_q && armed;

`ifdef FC_RESULT_FIFO_TIMESTAMP_EN
    logic [TS_BITS-1:0] ts_cnt;
    logic [TS_BITS-1:0] head_ts;

    // Free-running cycle counter captured into each entry
    always_ff @(posedge clk) begin
        if (!resetn) ts_cnt <= '0;
        else         ts_cnt <= ts_cnt + TS_BITS'(1);
    end

    assign wr_data = {ts_cnt, fc_ref_sys_cnt, fc_sig_cnt, fc_sig_sys_cnt, seq};
    assign head_ts = empty ? '0 : head[REF_LSB + SYS_BITS +: TS_BITS];
`else
    assign wr_data = {fc_ref_sys_cnt, fc_sig_cnt, fc_sig_sys_cnt, seq};
`endif

    // Head fields read as zero when nothing is queued
    assign head_seq    = empty ? '0 : head[0 +: SEQ_BITS];
    assign head_sigsys = empty ? '0 : head[SSYS_LSB +: SYS_BITS];
    assign head_sig    = empty ? '0 : head[SIG_LSB +: SIG_BITS];
    assign head_ref    = empty ? '0 : head[REF_LSB +: SYS_BITS];

    // Bus decode; requests are taken only while no ack is outstanding
    assign off = iomem_addr[7:0];
    assign hit = (iomem_addr[31:24] == DEC_PAGE) &&
                 ((off == OFF_STATUS)      || (off == OFF_HEAD_REF) ||
                  (off == OFF_HEAD_SIG)    || (off == OFF_HEAD_SIGSYS) ||
                  (off == OFF_POP)         || (off == OFF_DROPS) ||
                  (off == OFF_HEAD_TS));
    assign sel        = iomem_valid && !iomem_ready && hit;
    assign pop_req    = sel && (iomem_wstrb != 4'h0) && (off == OFF_POP);
    assign clr_req    = pop_req && iomem_wdata[POP_CLR_BIT];
    assign bus_unused = ^{iomem_addr[23:8], iomem_wdata[31:2], iomem_wdata[0]};

    // A pop frees the slot a same-cycle push needs, so full+pop accepts the push
    assign pop_ok    = pop_req && !empty;
    assign push_ok   = push_evt && (!full || pop_ok);
    assign drop      = push_evt && !push_ok;
    assign level_nxt = level + AW'(push_ok) - AW'(pop_ok);

    fc_result_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .resetn  (resetn),
        .push    (push_ok),
        .pop     (pop_ok),
        .wr_data (wr_data),
        .rd_data (head),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

    // Read data mux
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_STATUS: begin
                rd_val[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(level);
                rd_val[ST_EMPTY]                   = empty;
                rd_val[ST_FULL]                    = full;
                rd_val[ST_OVF]                     = ovf;
                rd_val[ST_SEQ_LSB +: ST_SEQ_W]     = ST_SEQ_W'(head_seq);
            end
            OFF_HEAD_REF:    rd_val = 32'(head_ref);
            OFF_HEAD_SIG:    rd_val = 32'(head_sig);
            OFF_HEAD_SIGSYS: rd_val = 32'(head_sigsys);
            OFF_DROPS:       rd_val[DROP_BITS-1:0] = drop_cnt;
`ifdef FC_RESULT_FIFO_TIMESTAMP_EN
            OFF_HEAD_TS:     rd_val = 32'(head_ts);
`endif
            default:         rd_val = '0;
        endcase
    end

    // Sequence, overflow bookkeeping, bus ack and irq
    always_ff @(posedge clk) begin
        if (!resetn) begin
            seq         <= '0;
            ovf         <= 1'b0;
            drop_cnt    <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            irq         <= 1'b0;
        end else begin
            if (push_evt) seq <= seq + SEQ_BITS'(1);

            if (clr_req) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != {DROP_BITS{1'b1}}) drop_cnt <= drop_cnt + DROP_BITS'(1);
            end

            iomem_ready <= sel;
            if (sel) iomem_rdata <= rd_val;

            irq <= (level_nxt != '0);
        end
    end

endmodule

// File: tb/tb_fc_result_fifo.sv
module tb_fc_result_fifo;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] A_STATUS = 32'h0300_0020;
    localparam logic [31:0] A_REF    = 32'h0300_0024;
    localparam logic [31:0] A_SIG    = 32'h0300_0028;
    localparam logic [31:0] A_SSYS   = 32'h0300_002C;
    localparam logic [31:0] A_POP    = 32'h0300_0030;
    localparam logic [31:0] A_DROPS  = 32'h0300_0034;
    localparam logic [31:0] A_TS     = 32'h0300_0038;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] fc_ref_sys_cnt;
    logic [31:0] fc_sig_cnt;
    logic [31:0] fc_sig_sys_cnt;
    logic        fc_ready;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    logic        irq;

    always #5 clk = ~clk;

    fc_result_fifo dut (
        .clk            (clk),
        .resetn         (resetn),
        .fc_ref_sys_cnt (fc_ref_sys_cnt),
        .fc_sig_cnt     (fc_sig_cnt),
        .fc_sig_sys_cnt (fc_sig_sys_cnt),
        .fc_ready       (fc_ready),
        .iomem_valid    (iomem_valid),
        .iomem_wstrb    (iomem_wstrb),
        .iomem_addr     (iomem_addr),
        .iomem_wdata    (iomem_wdata),
        .iomem_ready    (iomem_ready),
        .iomem_rdata    (iomem_rdata),
        .irq            (irq)
    );

    // Reference model: a queue of entries plus the spec's counters
    typedef struct packed {
        logic [31:0] r;
        logic [31:0] s;
        logic [31:0] ss;
        logic [15:0] seq;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_seq;
    bit          m_ovf;
    int unsigned m_drops;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void m_reset();
        mq.delete();
        m_seq = 0;
        m_ovf = 0;
        m_drops = 0;
    endfunction

    function automatic void m_op(input bit push, input bit pop, input bit clr,
                                 input logic [31:0] r, input logic [31:0] s,
                                 input logic [31:0] ss);
        ent_t e;
        if (pop) begin
            if (clr) begin
                m_ovf = 0;
                m_drops = 0;
            end
            if (mq.size() > 0) void'(mq.pop_front());
        end
        if (push) begin
            e.r = r; e.s = s; e.ss = ss; e.seq = 16'(m_seq);
            if (mq.size() < DEPTH) mq.push_back(e);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            m_seq = (m_seq + 1) % 65536;
        end
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] v = '0;
        v[6:0]  = 7'(mq.size());
        v[8]    = (mq.size() == 0);
        v[9]    = (mq.size() == DEPTH);
        v[10]   = m_ovf;
        if (mq.size() > 0) v[31:16] = mq[0].seq;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the ack of a request already on the bus
    task automatic wait_ack(input string tag);
        int cyc = 0;
        while (!iomem_ready && cyc < 8) begin
            tick();
            cyc++;
        end
        check(tag, {31'b0, iomem_ready}, 32'h1);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = 4'h0;
        iomem_wdata = $urandom;
        tick();
        wait_ack("rd_ack");
        data = iomem_rdata;
        iomem_valid = 1'b0;
        tick();
    endtask

    // One push and/or pop; when both, the edge and the POP select share a cycle
    task automatic do_op(input bit push, input bit pop, input bit clr, input logic [31:0] r);
        logic [31:0] wd;
        if (push) begin
            fc_ready       = 1'b1;
            fc_ref_sys_cnt = r;
            fc_sig_cnt     = $urandom;
            fc_sig_sys_cnt = $urandom;
        end
        if (pop) begin
            wd = $urandom;
            wd[1] = clr;
            iomem_valid = 1'b1;
            iomem_addr  = A_POP;
            iomem_wstrb = 4'(($urandom_range(1, 15)));
            iomem_wdata = wd;
        end
        m_op(push, pop, clr, r, fc_sig_cnt, fc_sig_sys_cnt);
        tick();
        fc_ready = 1'b0;
        if (pop) begin
            wait_ack("pop_ack");
            iomem_valid = 1'b0;
            iomem_wstrb = 4'h0;
        end
        tick();
    endtask

    task automatic check_head(input string tag);
        logic [31:0] d;
        bus_read(A_STATUS, d); check({tag, "_status"}, d, exp_status());
        bus_read(A_REF, d);    check({tag, "_ref"},    d, mq.size() > 0 ? mq[0].r  : 32'h0);
        bus_read(A_SIG, d);    check({tag, "_sig"},    d, mq.size() > 0 ? mq[0].s  : 32'h0);
        bus_read(A_SSYS, d);   check({tag, "_sigsys"}, d, mq.size() > 0 ? mq[0].ss : 32'h0);
        check({tag, "_irq"}, {31'b0, irq}, {31'b0, mq.size() > 0});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] prev;
        logic [15:0] s0;
        int acks;

        resetn = 1'b0;
        fc_ready = 1'b0;
        fc_ref_sys_cnt = '0;
        fc_sig_cnt = '0;
        fc_sig_sys_cnt = '0;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_addr = '0;
        iomem_wdata = '0;
        m_reset();
        repeat (3) tick();
        check("rst_ready", {31'b0, iomem_ready}, 32'h0);
        check("rst_rdata", iomem_rdata, 32'h0);
        check("rst_irq",   {31'b0, irq}, 32'h0);
        resetn = 1'b1;
        tick();
        bus_read(A_STATUS, d);
        check("rst_status", d, 32'h0000_0100);

        // Three pulses, then a pop
        do_op(1, 0, 0, 32'd100);
        do_op(1, 0, 0, 32'd200);
        do_op(1, 0, 0, 32'd300);
        bus_read(A_STATUS, d); check("three_status", d, 32'h0000_0003);
        bus_read(A_REF, d);    check("three_ref", d, 32'd100);
        check_head("three");
        do_op(0, 1, 0, 0);
        bus_read(A_REF, d);    check("pop_ref", d, 32'd200);
        bus_read(A_STATUS, d); check("pop_status", d, 32'h0001_0002);
        while (mq.size() > 0) begin
            check_head("drain_a");
            do_op(0, 1, 0, 0);
        end
        check_head("drained_a");

        // Overflow: 10 pulses into 8 slots, then clear via POP wdata=2
        for (int i = 0; i < 10; i++) do_op(1, 0, 0, $urandom);
        check_head("ovf");
        bus_read(A_STATUS, d); check("ovf_flags", d & 32'h0000_07FF, 32'h0000_0608);
        bus_read(A_DROPS, d);  check("ovf_drops", d, 32'd2);
        do_op(0, 1, 1, 0);
        bus_read(A_STATUS, d); check("clr_status", d & 32'h0000_07FF, 32'h0000_0007);
        bus_read(A_DROPS, d);  check("clr_drops", d, 32'd0);

        // Full, push edge and POP in the same cycle
        do_op(1, 0, 0, $urandom);
        bus_read(A_STATUS, d);
        s0 = d[31:16];
        check("full_again", d & 32'h0000_07FF, 32'h0000_0208);
        do_op(1, 1, 0, $urandom);
        bus_read(A_STATUS, d);
        check("pp_level", d & 32'h0000_07FF, 32'h0000_0208);
        check("pp_seq",   {16'h0, d[31:16]}, {16'h0, s0 + 16'd1});
        bus_read(A_DROPS, d);  check("pp_drops", d, 32'd0);
        while (mq.size() > 0) begin
            check_head("drain_b");
            do_op(0, 1, 0, 0);
        end

        // Held strobe pushes once; pop on empty still acks
        fc_ready = 1'b1;
        fc_ref_sys_cnt = $urandom;
        fc_sig_cnt = $urandom;
        fc_sig_sys_cnt = $urandom;
        m_op(1, 0, 0, fc_ref_sys_cnt, fc_sig_cnt, fc_sig_sys_cnt);
        repeat (5) tick();
        fc_ready = 1'b0;
        tick();
        check_head("held");
        do_op(0, 1, 0, 0);
        do_op(0, 1, 0, 0);
        check_head("pop_empty");

        // Edge push with POP on an empty FIFO keeps the push
        do_op(1, 1, 0, $urandom);
        check_head("pp_empty");

        // HEAD_TS
`ifdef FC_RESULT_FIFO_TIMESTAMP_EN
        while (mq.size() > 0) do_op(0, 1, 0, 0);
        do_op(1, 0, 0, $urandom);
        repeat (998) tick();
        do_op(1, 0, 0, $urandom);
        bus_read(A_TS, prev);
        do_op(0, 1, 0, 0);
        bus_read(A_TS, d);
        check("ts_delta", d - prev, 32'd1000);
`else
        bus_read(A_TS, d);
        check("ts_zero", d, 32'h0);
`endif

        // Undecoded addresses: no ack, rdata held
        bus_read(A_STATUS, prev);
        acks = 0;
        iomem_valid = 1'b1;
        iomem_addr = 32'h0300_0000;
        repeat (4) begin tick(); acks += int'(iomem_ready); end
        iomem_addr = 32'h0300_0040;
        repeat (4) begin tick(); acks += int'(iomem_ready); end
        iomem_valid = 1'b0;
        check("undec_acks", 32'(acks), 32'd0);
        check("undec_rdata", iomem_rdata, prev);

        // Back-to-back STATUS reads: one single-cycle ack per request
        acks = 0;
        iomem_valid = 1'b1;
        iomem_addr = A_STATUS;
        iomem_wstrb = 4'h0;
        repeat (4) begin
            tick();
            if (iomem_ready) begin
                acks++;
                check("b2b_data", iomem_rdata, exp_status());
            end
        end
        iomem_valid = 1'b0;
        tick();
        check("b2b_acks", 32'(acks), 32'd2);
        check("b2b_idle", {31'b0, iomem_ready}, 32'h0);

        // Randomized push/pop mix
        for (int i = 0; i < 40; i++) begin
            int op;
            op = int'($urandom_range(0, 4));
            do_op(op != 1, op == 1 || op == 2, ($urandom_range(0, 7) == 0), $urandom);
            bus_read(A_STATUS, d); check("rnd_status", d, exp_status());
            bus_read(A_DROPS, d);  check("rnd_drops", d, 32'(m_drops));
            if (op == 4) check_head("rnd_head");
        end

        // Reset mid-operation with a pending ack and fc_ready held high
        if (mq.size() == 0) do_op(1, 0, 0, $urandom);
        iomem_valid = 1'b1;
        iomem_addr = A_STATUS;
        tick();
        iomem_valid = 1'b0;
        resetn = 1'b0;
        fc_ready = 1'b1;
        tick();
        check("mid_rst_ready", {31'b0, iomem_ready}, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        m_reset();
        resetn = 1'b1;
        repeat (3) tick();
        fc_ready = 1'b0;
        tick();
        check_head("post_rst");
        do_op(1, 0, 0, $urandom);
        bus_read(A_STATUS, d); check("post_rst_push", d, 32'h0000_0001);
        bus_read(A_DROPS, d);  check("post_rst_drops", d, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
